// File: rtl/muxreg_arbiter_if.sv
// muxreg_arbiter_if: request/grant/select/load/ack bundle between the requesters and muxreg_arbiter
interface muxreg_arbiter_if;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [7:0] ack;
  logic [2:0] sel;
  logic load;
  logic busy;
  modport master (input req, output gnt, sel, load, ack, busy);
  modport slave (output req, input gnt, sel, load, ack, busy);
endinterface

// File: rtl/muxreg_arbiter.sv
// muxreg_arbiter: arbitrates 8 requesters onto one muxed register's sel/load and pulses a per-requester ack
module muxreg_arbiter #(
  parameter int PRIO_MODE = 0
) (
  input logic CLK,
  input logic RSTN,
  muxreg_arbiter_if.master bus
);
  typedef enum logic [1:0] {IDLE, LOAD, ACK} state_t;
  state_t state_q, state_d;
  logic [2:0] sel_q, sel_d, last_q, last_d, base, win;
  logic [7:0] gnt_q, gnt_d, elig;
  assign elig = bus.req & ~gnt_q;
  assign base = PRIO_MODE != 0 ? 3'd7 : last_q;
  always_comb begin
    win = '0;
    for (int i = 8; i >= 1; i--) win = elig[base + 3'(i)] ? base + 3'(i) : win;
  end
  always_comb begin
    state_d = state_q == LOAD ? ACK : |elig ? LOAD : IDLE;
    sel_d = state_q == LOAD ? sel_q : |elig ? win : 3'd0;
    gnt_d = state_q == LOAD ? gnt_q : |elig ? 8'd1 << win : 8'd0;
    last_d = state_q == LOAD && PRIO_MODE == 0 ? sel_q : last_q;
  end
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= IDLE;
      sel_q <= '0;
      gnt_q <= '0;
      last_q <= 3'd7;
    end else begin
      state_q <= state_d;
      sel_q <= sel_d;
      gnt_q <= gnt_d;
      last_q <= last_d;
    end
  end
  assign bus.gnt = gnt_q;
  assign bus.sel = sel_q;
  assign bus.load = state_q == LOAD;
  assign bus.ack = state_q == ACK ? gnt_q : 8'd0;
  assign bus.busy = state_q != IDLE;
endmodule

// File: tb/tb_muxreg_arbiter.sv
// tb_muxreg_arbiter: scoreboard bench for round-robin and fixed-priority muxreg_arbiter
module tb_muxreg_arbiter;
  logic CLK = 1'b0;
  logic RSTN = 1'b0;
  logic [15:0] q0, q1;
  int checks = 0;
  int errors = 0;
  int exp_q[2][$];
  always #5 CLK = ~CLK;
  muxreg_arbiter_if b0();
  muxreg_arbiter_if b1();
  muxreg_arbiter #(.PRIO_MODE(0)) dut0 (.CLK(CLK), .RSTN(RSTN), .bus(b0.master));
  muxreg_arbiter #(.PRIO_MODE(1)) dut1 (.CLK(CLK), .RSTN(RSTN), .bus(b1.master));
  function automatic logic [15:0] dv(input logic [2:0] i);
    return 16'h3c00 | 16'(i * 17 + 1);
  endfunction
  always @(posedge CLK or negedge RSTN)
    if (!RSTN) q0 <= '0;
    else if (b0.load) q0 <= dv(b0.sel);
  always @(posedge CLK or negedge RSTN)
    if (!RSTN) q1 <= '0;
    else if (b1.load) q1 <= dv(b1.sel);
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic mon(input int u, input logic [7:0] gnt, input logic [7:0] ack, input logic [2:0] sel,
                     input logic load, input logic [15:0] q);
    int w;
    chk($sformatf("gnt_onehot%0d", u), 32'($onehot0(gnt)), 1);
    chk($sformatf("ack_onehot%0d", u), 32'($onehot0(ack)), 1);
    chk($sformatf("ack_with_load%0d", u), 32'(load && ack != 0), 0);
    if (load) chk($sformatf("load_gnt%0d", u), 32'(gnt[sel]), 1);
    if (ack != 0) begin
      if (exp_q[u].size() == 0) chk($sformatf("unexpected_ack%0d", u), ack, 0);
      else begin
        w = exp_q[u].pop_front();
        chk($sformatf("ack%0d", u), ack, 8'd1 << w);
        chk($sformatf("q%0d", u), q, dv(3'(w)));
      end
    end
  endtask
  always @(negedge CLK)
    if (RSTN) begin
      mon(0, b0.gnt, b0.ack, b0.sel, b0.load, q0);
      mon(1, b1.gnt, b1.ack, b1.sel, b1.load, q1);
    end
  task automatic cyc();
    @(posedge CLK);
    #1;
    b0.req = b0.req & ~b0.ack;
    b1.req = b1.req & ~b1.ack;
  endtask
  task automatic wait_idle();
    for (int i = 0; i < 40 && (b0.busy || b1.busy); i++) cyc();
    chk("idle_timeout", 32'(b0.busy | b1.busy), 0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    b0.req = 8'hFF;
    b1.req = 8'h00;
    repeat (2) cyc();
    chk("rst_gnt", b0.gnt, 0);
    chk("rst_sel", b0.sel, 0);
    chk("rst_load", b0.load, 0);
    chk("rst_ack", b0.ack, 0);
    chk("rst_busy", b0.busy, 0);
    RSTN = 1'b1;
    for (int i = 0; i < 8; i++) exp_q[0].push_back(i);
    cyc();
    for (int i = 0; i < 8; i++) begin
      chk("rr_load", b0.load, 1);
      chk("rr_sel", b0.sel, 32'(i));
      cyc();
      chk("rr_ack_load", b0.load, 0);
      chk("rr_ack_busy", b0.busy, 1);
      cyc();
    end
    chk("rr_idle", b0.busy, 0);
    exp_q[0].push_back(0);
    exp_q[0].push_back(7);
    b0.req = 8'h81;
    cyc();
    chk("wrap_sel", b0.sel, 0);
    wait_idle();
    exp_q[0].push_back(5);
    b0.req = 8'h20;
    cyc();
    chk("single_load", b0.load, 1);
    chk("single_sel", b0.sel, 5);
    chk("single_gnt", b0.gnt, 8'h20);
    cyc();
    chk("single_ack_load", b0.load, 0);
    chk("single_ack_gnt", b0.gnt, 8'h20);
    cyc();
    chk("single_idle", b0.busy, 0);
    chk("single_gnt_clr", b0.gnt, 0);
    chk("single_sel_clr", b0.sel, 0);
    exp_q[0].push_back(2);
    exp_q[0].push_back(3);
    b0.req = 8'h0C;
    cyc();
    chk("b2b_load1", b0.load, 1);
    chk("b2b_sel1", b0.sel, 2);
    cyc();
    chk("b2b_gap_load", b0.load, 0);
    chk("b2b_gap_busy", b0.busy, 1);
    cyc();
    chk("b2b_load2", b0.load, 1);
    chk("b2b_sel2", b0.sel, 3);
    cyc();
    cyc();
    chk("b2b_idle", b0.busy, 0);
    exp_q[1].push_back(4);
    exp_q[1].push_back(1);
    exp_q[1].push_back(7);
    b1.req = 8'h90;
    cyc();
    chk("prio_sel", b1.sel, 4);
    chk("prio_load", b1.load, 1);
    b1.req = b1.req | 8'h02;
    wait_idle();
    b0.req = 8'h40;
    cyc();
    chk("abort_sel", b0.sel, 6);
    chk("abort_load", b0.load, 1);
    #2;
    RSTN = 1'b0;
    #1;
    chk("abort_gnt", b0.gnt, 0);
    chk("abort_load0", b0.load, 0);
    chk("abort_ack", b0.ack, 0);
    chk("abort_busy", b0.busy, 0);
    @(posedge CLK);
    #1;
    chk("abort_hold_ack", b0.ack, 0);
    RSTN = 1'b1;
    exp_q[0].push_back(6);
    cyc();
    chk("regrant_load", b0.load, 1);
    chk("regrant_sel", b0.sel, 6);
    wait_idle();
    chk("sb0_left", exp_q[0].size(), 0);
    chk("sb1_left", exp_q[1].size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
